// File: rtl/accumulator_ctrl_pkg.sv
// rtl/accumulator_ctrl_pkg.sv - shared widths and FSM encoding for the accumulator controller
package accumulator_ctrl_pkg;

  localparam int OPERAND_W = 8;
  localparam int ACC_W     = 16;
  localparam int COUNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/accumulator_ctrl_if.sv
// rtl/accumulator_ctrl_if.sv - operand stream and result handshake bundle
interface accumulator_ctrl_if;
  import accumulator_ctrl_pkg::*;

  logic                 in_valid;
  logic [OPERAND_W-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [ACC_W-1:0]     out_data;
  logic                 out_overflow;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow
  );

endinterface

// File: rtl/accumulator_ctrl_adder.sv
// rtl/accumulator_ctrl_adder.sv - combinational 8+16-bit adder, result mod 2^16
module Adder
  import accumulator_ctrl_pkg::*;
(
  input  logic [OPERAND_W-1:0] new_operand,
  input  logic [ACC_W-1:0]     current_value,
  output logic [ACC_W-1:0]     output_value
);

  assign output_value = {{(ACC_W-OPERAND_W){1'b0}}, new_operand} + current_value;

endmodule

// File: rtl/accumulator_ctrl.sv
// rtl/accumulator_ctrl.sv - sequences a counted operand job through the adder into a 16-bit total
module accumulator_ctrl
  import accumulator_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ACC_W-1:0]    init_value,
  input  logic [COUNT_W-1:0]  op_count,
  input  logic                abort,
  output logic                busy,
  accumulator_ctrl_if.slave   bus
);

  state_t               state, state_nxt;
  logic [ACC_W-1:0]     acc, acc_nxt;
  logic                 ovf, ovf_nxt;
  logic [COUNT_W-1:0]   remaining, remaining_nxt;
  logic [ACC_W-1:0]     sum;

  Adder u_adder (
    .new_operand   (bus.in_data),
    .current_value (acc),
    .output_value  (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      ovf       <= ovf_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    ovf_nxt       = ovf;
    remaining_nxt = remaining;
    if (abort) begin
      state_nxt     = ST_IDLE;
      acc_nxt       = '0;
      ovf_nxt       = 1'b0;
      remaining_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_nxt       = init_value;
            ovf_nxt       = 1'b0;
            remaining_nxt = op_count;
            state_nxt     = (op_count == '0) ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (bus.in_valid) begin
            acc_nxt       = sum;
            // the adder has no carry out; a smaller result means it wrapped
            ovf_nxt       = ovf | (sum < acc);
            remaining_nxt = remaining - 1'b1;
            if (remaining == COUNT_W'(1)) state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == ST_ACCUM);
  assign bus.out_valid    = (state == ST_DONE);
  assign bus.out_data     = (state == ST_DONE) ? acc : '0;
  assign bus.out_overflow = (state == ST_DONE) ? ovf : 1'b0;
  assign busy             = (state == ST_ACCUM) || (state == ST_DONE);

endmodule

// File: tb/tb_accumulator_ctrl.sv
// tb/tb_accumulator_ctrl.sv - directed and randomized jobs checked against an arithmetic job model
module tb_accumulator_ctrl;
  import accumulator_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic [15:0] init_value = '0;
  logic [7:0]  op_count = '0;
  int          checks = 0;
  int          errors = 0;
  int          accepts = 0;
  logic [7:0]  ops [$];

  accumulator_ctrl_if bus();

  accumulator_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .init_value (init_value),
    .op_count   (op_count),
    .abort      (abort),
    .busy       (busy),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && !abort && bus.in_valid && bus.in_ready) accepts++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result comes from the exact integer sum: with non-negative operands
  // the job wrapped at least once exactly when that sum exceeds 16 bits.
  task automatic run_job(input string tag, input logic [15:0] init, input int gap, input int stall);
    int          total;
    int          n;
    int          g;
    logic [15:0] exp_d;
    logic        exp_o;
    n = ops.size();
    total = int'(init);
    foreach (ops[i]) total += int'(ops[i]);
    exp_d = total[15:0];
    exp_o = (total > 65535);
    accepts = 0;
    check({tag, " idle busy"}, busy, 0);
    start = 1'b1; init_value = init; op_count = n[7:0];
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      repeat (g) begin
        bus.in_valid = 1'b0;
        check({tag, " in_ready in gap"}, bus.in_ready, 1);
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = ops[i];
      check({tag, " out_data zero in accum"}, bus.out_data, 0);
      check({tag, " no early out_valid"}, bus.out_valid, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom_range(255, 0);
    check({tag, " out_valid latency"}, bus.out_valid, 1);
    check({tag, " accept count"}, accepts, n);
    check({tag, " in_ready low in done"}, bus.in_ready, 0);
    repeat (stall) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      check({tag, " stall out_valid"}, bus.out_valid, 1);
      check({tag, " stall out_data"}, bus.out_data, exp_d);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, " out_data"}, bus.out_data, exp_d);
    check({tag, " out_overflow"}, bus.out_overflow, exp_o);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " idle after handshake"}, busy, 0);
    check({tag, " out_valid cleared"}, bus.out_valid, 0);
    check({tag, " out_data reads zero"}, bus.out_data, 0);
    check({tag, " accepts unchanged"}, accepts, n);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #2;
    check("reset busy", busy, 0);
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_data", bus.out_data, 0);
    check("reset out_overflow", bus.out_overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    ops = '{8'h10, 8'h20, 8'h30};
    run_job("basic", 16'h0000, 0, 0);
    ops = '{8'h20, 8'h05};
    run_job("wrap", 16'hFFF0, 0, 0);
    ops = '{};
    run_job("empty", 16'h1234, 0, 2);
    ops = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_job("backpressure", 16'h0000, 2, 5);

    // abort after two of five operands, with a third operand presented alongside abort
    accepts = 0;
    start = 1'b1; init_value = 16'h4321; op_count = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      bus.in_valid = 1'b1; bus.in_data = $urandom_range(255, 0);
      @(negedge clk);
    end
    bus.in_data = 8'h77; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus.in_valid = 1'b0;
    check("abort busy", busy, 0);
    check("abort out_valid", bus.out_valid, 0);
    check("abort in_ready", bus.in_ready, 0);
    check("abort accepts", accepts, 2);
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("abort no result", bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;
    ops = '{8'h01, 8'h01};
    run_job("after abort", 16'h0000, 0, 0);

    // asynchronous reset between edges while accumulating
    start = 1'b1; init_value = 16'hABCD; op_count = 8'd3;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h11;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst busy", busy, 0);
    check("rst in_ready", bus.in_ready, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_data", bus.out_data, 0);
    check("rst out_overflow", bus.out_overflow, 0);
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post rst no stale result", bus.out_valid, 0);
      check("post rst idle", busy, 0);
    end
    bus.out_ready = 1'b0;
    ops = '{8'h80, 8'h90, 8'h7F};
    run_job("after rst", 16'hFF00, 1, 1);

    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(6, 0);
      ops = '{};
      for (int k = 0; k < n; k++) ops.push_back(8'($urandom_range(255, 0)));
      run_job($sformatf("rand%0d", j), 16'($urandom_range(65535, 0)), -1,
              int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accumulator_ctrl.md
# accumulator_ctrl

Sequencing stage that owns the running 16-bit accumulator register of the adder/accumulator datapath. It loads an initial value, accepts a programmed number of 8-bit operands over a valid/ready stream, and feeds each operand plus the registered running total through the combinational 8+16-bit adder. It returns the final 16-bit total, with a sticky wrap flag, over a second valid/ready handshake.

## Interface
- Parameters: none. Widths are fixed: 8-bit operand, 16-bit accumulator, 8-bit operand count.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a job; sampled only in IDLE.
- `init_value` input 16: accumulator preload, captured on accepted `start`.
- `op_count` input 8: number of operands in the job, captured on accepted `start`; 0 = no operands.
- `abort` input 1: synchronous cancel; returns to IDLE from any state.
- `in_valid` input 1: operand present.
- `in_data` input 8: operand.
- `in_ready` output 1: high only in ACCUM.
- `out_valid` output 1: high only in DONE.
- `out_data` output 16: final total, valid while `out_valid`.
- `out_overflow` output 1: sticky, set if any addition in the job wrapped past 0xFFFF.
- `out_ready` input 1: result consumer ready.
- `busy` output 1: high in ACCUM or DONE.

## Operation
- States: IDLE, ACCUM, DONE. Encoding is held in the shared package.
- IDLE:
  - `start` & !`abort` → `acc`←`init_value`, `ovf`←0, `remaining`←`op_count`.
  - Next state is DONE if `op_count`==0, else ACCUM.
- ACCUM:
  - Accept when `in_valid` & `in_ready` → `acc`←`sum`, `ovf`←`ovf` | (`sum` < `acc`), `remaining`←`remaining`−1.
  - If `remaining`==1 on an accept, next state is DONE.
  - `start` is ignored.
- DONE:
  - `out_data`=`acc`, `out_overflow`=`ovf`.
  - `out_valid` & `out_ready` → IDLE.
  - `acc` is held until the next accepted `start`.
- Arithmetic:
  - `sum` = {8'h00, `in_data`} + `acc`, computed mod 2^16.
  - Wrap detection is an unsigned compare of `sum` against `acc`, since the adder exposes no carry out.
  - No saturation.
- `abort` has priority over every other input:
  - next state is IDLE, and `ovf` and `remaining` are cleared;
  - `acc` is cleared to 0;
  - an operand presented in the same cycle is not consumed, and a result presented in the same cycle is not delivered.
- `in_valid` in IDLE or DONE is ignored; no operand is consumed.
- `out_data` and `out_overflow` read 0 outside DONE.

## Timing
- Reset (async assert, sync deassert assumed at top level):
  - state=IDLE, `acc`=0, `ovf`=0, `remaining`=0;
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `out_overflow`=0, `busy`=0.
- All outputs decode from registered state/`acc`/`ovf`; there is no combinational input→output path.
- Throughput: 1 operand per cycle while `in_valid` is held high.
- Latency:
  - `out_valid` rises the cycle after the last operand is accepted.
  - For `op_count`==0, `out_valid` rises the cycle after `start`.
- Result is held stable under backpressure until `out_ready`. The earliest next `start` is the cycle after the result handshake.
- `rst` mid-job discards the job immediately (asynchronously), with no result emitted.

## Structure
- Shared package holds:
  - the state enum (IDLE/ACCUM/DONE);
  - width constants OPERAND_W=8, ACC_W=16, COUNT_W=8.
- One sub-module: the existing `Adder` (8-bit `new_operand` + 16-bit `current_value` → 16-bit `output_value`), instantiated once with `acc` on `current_value`. No second adder; the `remaining` decrement is a plain counter.

## Test plan
- Basic job: `init_value`=0x0000, `op_count`=3, operands 0x10, 0x20, 0x30 on consecutive cycles → `out_valid` the cycle after the third accept, `out_data`=0x0060, `out_overflow`=0.
- Wrap: `init_value`=0xFFF0, `op_count`=2, operands 0x20, 0x05 → `out_data`=0x0015, `out_overflow`=1, with the flag remaining set after the second add.
- Empty job: `op_count`=0, `init_value`=0x1234 → no `in_ready`, `out_valid` the next cycle, `out_data`=0x1234, `out_overflow`=0.
- Backpressure:
  - stimulus: `op_count`=4 of 0xFF with `in_valid` gaps of 2 cycles, then `out_ready` low for 5 cycles;
  - required response: exactly 4 accepts, `out_data`=0x03FC stable throughout the stall, and IDLE the cycle after `out_ready`.
- Abort: `abort` pulsed after 2 of 5 operands → IDLE next cycle, `busy`=0, no `out_valid`. A following job with `init_value`=0, operands 0x01 ×2 → 0x0002.
- Async reset mid-job: `rst` asserted between clock edges during ACCUM → all outputs 0 immediately. After release, no stale result appears and a new job completes correctly.
